// File: rtl/branch_pkg.sv
// Shared types and constants for branch/jump resolution.
// The compare encoding is also used by the external comparator.
package branch_pkg;

    typedef enum logic [1:0] {
        KIND_BR   = 2'b00,
        KIND_JAL  = 2'b01,
        KIND_JALR = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    localparam logic [2:0] CMP_EQ = 3'b000;
    localparam logic [2:0] CMP_NE = 3'b001;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_GE = 3'b011;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LE = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_REDIRECT,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/branch_resolve_if.sv
// Request, comparator and redirect signals of the branch resolution unit.
// slave is the unit itself; master is the surrounding decode/fetch/comparator side.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [2:0]      req_funct3;
    logic [1:0]      req_kind;
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic [2:0]      cmp_funct3;
    logic            cmp_flag;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            link_valid;
    logic [XLEN-1:0] link_data;
    logic            flush;
    logic            misalign;

    modport slave (
        input  req_valid, req_pc, req_imm, req_rs1, req_rs2, req_funct3, req_kind,
        input  cmp_flag, redirect_ready,
        output req_ready, cmp_a, cmp_b, cmp_funct3, redirect_valid, redirect_pc,
        output link_valid, link_data, flush, misalign
    );

    modport master (
        output req_valid, req_pc, req_imm, req_rs1, req_rs2, req_funct3, req_kind,
        output cmp_flag, redirect_ready,
        input  req_ready, cmp_a, cmp_b, cmp_funct3, redirect_valid, redirect_pc,
        input  link_valid, link_data, flush, misalign
    );
endinterface

// File: rtl/branch_target.sv
// Combinational target adder: pc+imm for BR/JAL, (rs1+imm)&~1 for JALR,
// plus the bit1 misalignment check on the resulting target.
module branch_target
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  kind_e           kind,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign base       = (kind == KIND_JALR) ? rs1 : pc;
    assign sum        = base + imm;
    assign target     = (kind == KIND_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;
    assign misaligned = target[1];

endmodule

// File: rtl/branch_resolve.sv
// Sequential branch/jump resolver: accept, evaluate via external comparator,
// issue a PC redirect, then hold flush for FLUSH_CYCLES.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    branch_resolve_if.slave  bus
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic [XLEN-1:0]  pc_reg, imm_reg, rs1_reg, rs2_reg;
    logic [2:0]       funct3_reg;
    kind_e            kind_reg;
    logic [XLEN-1:0]  link_reg;
    logic [XLEN-1:0]  redirect_pc_reg;

    logic [XLEN-1:0]  target;
    logic             misaligned;
    logic             accept, is_jump, taken, do_redirect;

    branch_target #(.XLEN(XLEN)) u_target (
        .kind       (kind_reg),
        .pc         (pc_reg),
        .imm        (imm_reg),
        .rs1        (rs1_reg),
        .target     (target),
        .misaligned (misaligned)
    );

    assign accept      = (state_reg == ST_IDLE) && bus.req_valid;
    assign is_jump     = (kind_reg == KIND_JAL) || (kind_reg == KIND_JALR);
    // Reserved kind falls through here as never taken.
    assign taken       = is_jump || ((kind_reg == KIND_BR) && bus.cmp_flag);
    assign do_redirect = (state_reg == ST_EVAL) && taken && !misaligned;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_IDLE:  if (bus.req_valid) state_next = ST_EVAL;
            ST_EVAL:  state_next = do_redirect ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg > CNT_W'(1)) begin
                    flush_cnt_next = flush_cnt_reg - CNT_W'(1);
                end else begin
                    flush_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            flush_cnt_reg   <= '0;
            pc_reg          <= '0;
            imm_reg         <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
            funct3_reg      <= '0;
            kind_reg        <= KIND_BR;
            link_reg        <= '0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            if (accept) begin
                pc_reg     <= bus.req_pc;
                imm_reg    <= bus.req_imm;
                rs1_reg    <= bus.req_rs1;
                rs2_reg    <= bus.req_rs2;
                funct3_reg <= bus.req_funct3;
                kind_reg   <= kind_e'(bus.req_kind);
                link_reg   <= bus.req_pc + XLEN'(4);
            end
            if (do_redirect) redirect_pc_reg <= target;
        end
    end

    // Comparator operands come straight from registers, never from req_*.
    assign bus.cmp_a          = rs1_reg;
    assign bus.cmp_b          = rs2_reg;
    assign bus.cmp_funct3     = funct3_reg;
    assign bus.req_ready      = (state_reg == ST_IDLE);
    assign bus.redirect_valid = (state_reg == ST_REDIRECT);
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.link_valid     = (state_reg == ST_EVAL) && is_jump;
    assign bus.link_data      = link_reg;
    assign bus.misalign       = (state_reg == ST_EVAL) && taken && misaligned;
    assign bus.flush          = (state_reg == ST_FLUSH) && (flush_cnt_reg != '0);

endmodule
